// File: rtl/bcd_chain_pkg.sv
// Shared types and constants for the cascaded BCD run controller.
// State encoding is fixed so that debug taps see stable codes.
package bcd_chain_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Out-of-range nibbles from the control panel saturate to 9.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] nibble);
    return (nibble > DIGIT_W'(BCD_MAX)) ? DIGIT_W'(BCD_MAX) : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the chain: load beats increment, wraps 9 -> 0.
module bcd_digit
  import bcd_chain_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max
);

  assign at_max = (q == DIGIT_W'(BCD_MAX));

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= ld_val;
    else if (en) q <= at_max ? '0 : q + DIGIT_W'(1);
  end

endmodule

// File: rtl/bcd_chain_ctrl.sv
// Stopwatch run controller: FSM, prescaler, ripple-enable digit chain,
// terminal-count compare against LIMIT and DONE/WRAP pulse generation.
module bcd_chain_ctrl
  import bcd_chain_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                    CLK_in,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    CLEAR,
  input  logic                    LOAD,
  input  logic [DIGITS*DIGIT_W-1:0] LOAD_val,
  input  logic [DIGITS*DIGIT_W-1:0] LIMIT,
  output logic [DIGITS*DIGIT_W-1:0] BCD_out,
  output logic                    RUNNING,
  output logic                    DONE,
  output logic                    WRAP
);

  localparam int W  = DIGITS * DIGIT_W;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t          state, nxt;
  logic [PW-1:0]   presc;
  logic            tick, cnt_en, presc_run, presc_clr, chain_ld, done_n, wrap_n, lim_ok;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS:0]   ripple;
  logic [W-1:0]      inc_val, ld_data, ld_clamped;

  assign tick      = (state == ST_RUN) && (presc == PW'(PRESCALE - 1));
  assign ripple[0] = 1'b1;

  // ripple[] is the carry into each digit assuming a tick; inc_val is the
  // would-be next count, used for the terminal compare on the same edge.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_digit (
      .clk    (CLK_in),
      .rst    (RESET),
      .en     (cnt_en & ripple[g]),
      .ld     (chain_ld),
      .ld_val (ld_data[g*DIGIT_W +: DIGIT_W]),
      .q      (BCD_out[g*DIGIT_W +: DIGIT_W]),
      .at_max (at_max[g])
    );
    assign ripple[g+1] = ripple[g] & at_max[g];
    assign inc_val[g*DIGIT_W +: DIGIT_W] = !ripple[g] ? BCD_out[g*DIGIT_W +: DIGIT_W] :
                                           at_max[g] ? '0 :
                                           BCD_out[g*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
    assign ld_clamped[g*DIGIT_W +: DIGIT_W] = bcd_clamp(LOAD_val[g*DIGIT_W +: DIGIT_W]);
  end

  always_comb begin
    lim_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (LIMIT[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) lim_ok = 1'b0;
  end

  always_ff @(posedge CLK_in) begin
    if (RESET) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    chain_ld  = 1'b0;
    ld_data   = '0;
    presc_clr = 1'b0;
    presc_run = 1'b0;
    cnt_en    = 1'b0;
    done_n    = 1'b0;
    wrap_n    = 1'b0;
    if (CLEAR) begin
      nxt       = ST_IDLE;
      chain_ld  = 1'b1;
      presc_clr = 1'b1;
    end else if (LOAD && state != ST_RUN) begin
      nxt       = ST_IDLE;
      chain_ld  = 1'b1;
      ld_data   = ld_clamped;
      presc_clr = 1'b1;
    end else if (STOP) begin
      // Pausing freezes both count and prescaler, even on a tick edge.
      if (state == ST_RUN) nxt = ST_PAUSE;
    end else if (state == ST_RUN) begin
      presc_run = 1'b1;
      cnt_en    = tick;
      if (tick) begin
        wrap_n = ripple[DIGITS];
        if (lim_ok && inc_val == LIMIT) begin
          nxt    = ST_HALT;
          done_n = 1'b1;
        end
      end
    end else if (START && (state == ST_IDLE || state == ST_PAUSE)) begin
      nxt = ST_RUN;
    end
  end

  always_ff @(posedge CLK_in) begin
    if (RESET) begin
      presc   <= '0;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
      WRAP    <= 1'b0;
    end else begin
      if (presc_clr)      presc <= '0;
      else if (presc_run) presc <= tick ? '0 : presc + PW'(1);
      RUNNING <= (nxt == ST_RUN);
      DONE    <= done_n;
      WRAP    <= wrap_n;
    end
  end

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Scoreboard bench for bcd_chain_ctrl (DIGITS=2, PRESCALE=2): a decimal
// reference model pushes expected outputs each edge, popped after the edge.
module tb_bcd_chain_ctrl;

  localparam int DIG = 2;
  localparam int PRE = 2;
  localparam int MOD = 100;

  typedef struct {
    logic [7:0] bcd;
    logic       run;
    logic       done;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, stop, clr, ld;
  logic [7:0] ld_val, limit, bcd;
  logic       running, done, wrap;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   m_cnt = 0, m_st = 0, m_pre = 0;
  bit   m_done = 0, m_wrap = 0;
  int   done_seen = 0, wrap_seen = 0;

  bcd_chain_ctrl #(.DIGITS(DIG), .PRESCALE(PRE)) dut (
    .CLK_in(clk), .RESET(rst), .START(start), .STOP(stop), .CLEAR(clr),
    .LOAD(ld), .LOAD_val(ld_val), .LIMIT(limit), .BCD_out(bcd),
    .RUNNING(running), .DONE(done), .WRAP(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic int dec_of(input logic [7:0] v);
    int r = 0;
    for (int i = DIG - 1; i >= 0; i--) begin
      logic [3:0] n;
      n = v[i*4 +: 4];
      if (n > 4'd9) n = 4'd9;
      r = r * 10 + int'(n);
    end
    return r;
  endfunction

  function automatic bit valid_bcd(input logic [7:0] v);
    for (int i = 0; i < DIG; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] to_bcd(input int c);
    logic [7:0] r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[i*4 +: 4] = 4'(c % 10);
      c = c / 10;
    end
    return r;
  endfunction

  // Model states: 0 idle, 1 run, 2 pause, 3 halt.
  task automatic model_step();
    exp_t e;
    if (rst) begin
      m_cnt = 0; m_st = 0; m_pre = 0; m_done = 0; m_wrap = 0;
    end else begin
      m_done = 0; m_wrap = 0;
      if (clr) begin
        m_cnt = 0; m_pre = 0; m_st = 0;
      end else if (ld && m_st != 1) begin
        m_cnt = dec_of(ld_val); m_pre = 0; m_st = 0;
      end else if (stop) begin
        if (m_st == 1) m_st = 2;
      end else if (m_st == 1) begin
        if (m_pre == PRE - 1) begin
          m_pre = 0;
          m_cnt = (m_cnt + 1) % MOD;
          if (m_cnt == 0) m_wrap = 1;
          if (valid_bcd(limit) && m_cnt == dec_of(limit)) begin
            m_done = 1; m_st = 3;
          end
        end else m_pre++;
      end else if (start && (m_st == 0 || m_st == 2)) m_st = 1;
    end
    e.bcd = to_bcd(m_cnt); e.run = (m_st == 1); e.done = m_done; e.wrap = m_wrap;
    q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("bcd", 32'(bcd), 32'(e.bcd));
    chk("running", 32'(running), 32'(e.run));
    chk("done", 32'(done), 32'(e.done));
    chk("wrap", 32'(wrap), 32'(e.wrap));
    if (done) done_seen++;
    if (wrap) wrap_seen++;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; clr = 0; ld = 0; ld_val = 8'h00; limit = 8'hFF;
    cyc(); cyc();
    chk("reset_bcd", 32'(bcd), 32'h00);

    // Basic count from zero
    rst = 0; start = 1;
    repeat (5) cyc();
    chk("s1_count", 32'(bcd), 32'h02);

    // Preset then full-scale rollover
    start = 0; clr = 1; cyc();
    clr = 0; ld = 1; ld_val = 8'h95; cyc();
    chk("s2_load", 32'(bcd), 32'h95);
    ld = 0; start = 1; wrap_seen = 0;
    repeat (13) cyc();
    chk("s2_after_wrap", 32'(bcd), 32'h01);
    chk("s2_wrap_cnt", 32'(wrap_seen), 32'd1);

    // Terminal count halt
    start = 0; clr = 1; cyc();
    clr = 0; limit = 8'h12; start = 1; done_seen = 0;
    repeat (30) cyc();
    chk("s3_hold", 32'(bcd), 32'h12);
    chk("s3_halted", 32'(running), 32'd0);
    chk("s3_done_cnt", 32'(done_seen), 32'd1);
    start = 0; clr = 1; cyc();
    chk("s3_clear", 32'(bcd), 32'h00);

    // Stop on a tick edge, then resume
    clr = 0; limit = 8'hFF; start = 1;
    for (int i = 0; i < 100 && !(m_cnt == 5 && m_pre == PRE - 1 && m_st == 1); i++) cyc();
    chk("s4_at05", 32'(bcd), 32'h05);
    stop = 1; cyc();
    chk("s4_paused", 32'(bcd), 32'h05);
    chk("s4_notrun", 32'(running), 32'd0);
    repeat (2) cyc();
    stop = 0; cyc();
    chk("s4_resumed", 32'(running), 32'd1);
    cyc();
    chk("s4_06", 32'(bcd), 32'h06);

    // Load ignored in run, clamped in idle
    ld = 1; ld_val = 8'h33; cyc();
    chk("s5_ld_ignored", 32'(running), 32'd1);
    ld = 0; start = 0; clr = 1; cyc();
    clr = 0; ld = 1; ld_val = 8'hA3; cyc();
    chk("s5_clamp", 32'(bcd), 32'h93);

    // Load of LIMIT value does not pulse DONE; next tick passes it
    ld_val = 8'h30; limit = 8'h30; done_seen = 0; cyc();
    ld = 0; start = 1;
    repeat (3) cyc();
    chk("s5_past_limit", 32'(bcd), 32'h31);
    chk("s5_no_done", 32'(done_seen), 32'd0);

    // Reset mid-count
    start = 0; clr = 1; limit = 8'hFF; cyc();
    clr = 0; ld = 1; ld_val = 8'h46; cyc();
    ld = 0; start = 1;
    for (int i = 0; i < 20 && m_cnt != 47; i++) cyc();
    chk("s6_at47", 32'(bcd), 32'h47);
    rst = 1; cyc();
    chk("s6_rst_bcd", 32'(bcd), 32'h00);
    chk("s6_rst_run", 32'(running), 32'd0);
    rst = 0;

    // Random command mix against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0)
        limit = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 40));
      rst    = ($urandom_range(0, 199) == 0);
      clr    = ($urandom_range(0, 59) == 0);
      ld     = ($urandom_range(0, 29) == 0);
      stop   = ($urandom_range(0, 14) == 0);
      start  = ($urandom_range(0, 3) != 0);
      ld_val = 8'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
